// File: rtl/regfile_pkg.sv
// ============================================================================
// Module      : regfile_pkg
// Description : Shared constants, lane-count helper and word type for the
//               register file and its byte-masked storage element.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

package regfile_pkg;

    localparam int c_DEFAULT_DATA_WIDTH = 32;
    localparam int c_DEFAULT_NUM_REGS   = 16;
    localparam int c_DEFAULT_ADDR_WIDTH = 4;

    typedef logic [c_DEFAULT_DATA_WIDTH-1:0] reg_word_t;

    function automatic int num_lanes(input int data_width);
        return data_width / 8;
    endfunction

endpackage : regfile_pkg

`default_nettype wire

// File: rtl/byte_mask_register.sv
// ============================================================================
// Module      : byte_mask_register
// Description : One DATA_WIDTH register with synchronous clear to INIT and
//               per-byte write enables.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module byte_mask_register
    import regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic                             enable,
    input  logic [num_lanes(DATA_WIDTH)-1:0] mask,
    input  logic [DATA_WIDTH-1:0]            d,
    output logic [DATA_WIDTH-1:0]            q
);

    localparam int c_LANES = num_lanes(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] r_q;

    always_ff @(posedge clock) begin
        if (clear) begin
            r_q <= INIT;
        end else if (enable) begin
            for (int l = 0; l < c_LANES; l++) begin
                if (mask[l]) begin
                    r_q[l*8 +: 8] <= d[l*8 +: 8];
                end
            end
        end
    end

    assign q = r_q;

endmodule : byte_mask_register

`default_nettype wire

// File: rtl/register_file.sv
// ============================================================================
// Module      : register_file
// Description : NUM_REGS x DATA_WIDTH register file, one byte-masked write
//               port, two registered read ports with optional write bypass.
//               Macro REGFILE_R0_ZERO_EN hard-wires register 0 to zero.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module register_file
    import regfile_pkg::*;
#(
    parameter int                    DATA_WIDTH = c_DEFAULT_DATA_WIDTH,
    parameter int                    NUM_REGS   = c_DEFAULT_NUM_REGS,
    parameter int                    ADDR_WIDTH = c_DEFAULT_ADDR_WIDTH,
    parameter logic [DATA_WIDTH-1:0] INIT       = '0,
    parameter int                    BYPASS     = 1
) (
    input  logic                             clock,
    input  logic                             clear,
    input  logic                             wr_en,
    input  logic [ADDR_WIDTH-1:0]            wr_addr,
    input  logic [DATA_WIDTH-1:0]            wr_data,
    input  logic [num_lanes(DATA_WIDTH)-1:0] wr_mask,
    input  logic [ADDR_WIDTH-1:0]            rd_addr_a,
    output logic [DATA_WIDTH-1:0]            rd_data_a,
    input  logic [ADDR_WIDTH-1:0]            rd_addr_b,
    output logic [DATA_WIDTH-1:0]            rd_data_b
);

    localparam int                c_LANES    = num_lanes(DATA_WIDTH);
    localparam int                c_DEPTH    = 1 << ADDR_WIDTH;
    localparam logic [ADDR_WIDTH:0] c_NUM_REGS = (ADDR_WIDTH+1)'(NUM_REGS);

    // Fully populated address space: slots past NUM_REGS read as zero.
    logic [DATA_WIDTH-1:0] w_q [c_DEPTH];
    logic                  w_wr_valid;
    logic [DATA_WIDTH-1:0] w_wr_merged;
    logic [DATA_WIDTH-1:0] w_rd_next_a;
    logic [DATA_WIDTH-1:0] w_rd_next_b;
    logic [DATA_WIDTH-1:0] r_rd_data_a;
    logic [DATA_WIDTH-1:0] r_rd_data_b;

    always_comb begin
        w_wr_valid = wr_en && ({1'b0, wr_addr} < c_NUM_REGS);
`ifdef REGFILE_R0_ZERO_EN
        w_wr_valid = w_wr_valid && (wr_addr != '0);
`endif
    end

    for (genvar gi = 0; gi < c_DEPTH; gi++) begin : g_regs
        if (gi >= NUM_REGS) begin : g_unused
            assign w_q[gi] = '0;
        end
`ifdef REGFILE_R0_ZERO_EN
        else if (gi == 0) begin : g_r0
            assign w_q[gi] = '0;
        end
`endif
        else begin : g_reg
            byte_mask_register #(
                .DATA_WIDTH (DATA_WIDTH),
                .INIT       (INIT)
            ) u_reg (
                .clock  (clock),
                .clear  (clear),
                .enable (w_wr_valid && (wr_addr == ADDR_WIDTH'(gi))),
                .mask   (wr_mask),
                .d      (wr_data),
                .q      (w_q[gi])
            );
        end
    end

    // Value the write target will hold after this edge.
    always_comb begin
        w_wr_merged = w_q[wr_addr];
        for (int l = 0; l < c_LANES; l++) begin
            if (wr_mask[l]) begin
                w_wr_merged[l*8 +: 8] = wr_data[l*8 +: 8];
            end
        end
    end

    always_comb begin
        w_rd_next_a = w_q[rd_addr_a];
        w_rd_next_b = w_q[rd_addr_b];
        if ((BYPASS != 0) && w_wr_valid) begin
            if (rd_addr_a == wr_addr) begin
                w_rd_next_a = w_wr_merged;
            end
            if (rd_addr_b == wr_addr) begin
                w_rd_next_b = w_wr_merged;
            end
        end
    end

    always_ff @(posedge clock) begin
        if (clear) begin
            r_rd_data_a <= '0;
            r_rd_data_b <= '0;
        end else begin
            r_rd_data_a <= w_rd_next_a;
            r_rd_data_b <= w_rd_next_b;
        end
    end

    assign rd_data_a = r_rd_data_a;
    assign rd_data_b = r_rd_data_b;

endmodule : register_file

`default_nettype wire

// File: tb/tb_register_file.sv
// ============================================================================
// Module      : tb_register_file
// Description : Directed self-checking bench; dut_a is 16 regs with bypass,
//               dut_b is 12 regs without bypass, both sharing one stimulus.
// Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_register_file;
    import regfile_pkg::*;

    localparam reg_word_t c_INIT = 32'hDEAD_BEEF;

    logic      clock;
    logic      clear;
    logic      wr_en;
    logic [3:0] wr_addr;
    reg_word_t wr_data;
    logic [3:0] wr_mask;
    logic [3:0] rd_addr_a;
    logic [3:0] rd_addr_b;
    reg_word_t a_rd_a, a_rd_b, b_rd_a, b_rd_b;

    int total = 0;
    int bad   = 0;

    register_file #(
        .DATA_WIDTH (32), .NUM_REGS (16), .ADDR_WIDTH (4),
        .INIT (c_INIT), .BYPASS (1)
    ) dut_a (
        .clock (clock), .clear (clear), .wr_en (wr_en), .wr_addr (wr_addr),
        .wr_data (wr_data), .wr_mask (wr_mask),
        .rd_addr_a (rd_addr_a), .rd_data_a (a_rd_a),
        .rd_addr_b (rd_addr_b), .rd_data_b (a_rd_b)
    );

    register_file #(
        .DATA_WIDTH (32), .NUM_REGS (12), .ADDR_WIDTH (4),
        .INIT (c_INIT), .BYPASS (0)
    ) dut_b (
        .clock (clock), .clear (clear), .wr_en (wr_en), .wr_addr (wr_addr),
        .wr_data (wr_data), .wr_mask (wr_mask),
        .rd_addr_a (rd_addr_a), .rd_data_a (b_rd_a),
        .rd_addr_b (rd_addr_b), .rd_data_b (b_rd_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    // Inputs change 1 time unit after the edge; outputs are sampled there too.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic write(input logic [3:0] addr, input reg_word_t data, input logic [3:0] mask);
        wr_en   = 1'b1;
        wr_addr = addr;
        wr_data = data;
        wr_mask = mask;
    endtask

    task automatic test_reset();
        clear = 1'b1; wr_en = 1'b0; rd_addr_a = 4'd3; rd_addr_b = 4'd15;
        step();
        total++; if (a_rd_a !== 32'd0) begin bad++; $display("FAIL reset_rd_a_a got=%h want=%h", a_rd_a, 32'd0); end
        total++; if (a_rd_b !== 32'd0) begin bad++; $display("FAIL reset_rd_a_b got=%h want=%h", a_rd_b, 32'd0); end
        total++; if (b_rd_a !== 32'd0) begin bad++; $display("FAIL reset_rd_b_a got=%h want=%h", b_rd_a, 32'd0); end
        clear = 1'b0;
        step();
        total++; if (a_rd_a !== c_INIT) begin bad++; $display("FAIL init_r3_a got=%h want=%h", a_rd_a, c_INIT); end
        total++; if (a_rd_b !== c_INIT) begin bad++; $display("FAIL init_r15_a got=%h want=%h", a_rd_b, c_INIT); end
        total++; if (b_rd_a !== c_INIT) begin bad++; $display("FAIL init_r3_b got=%h want=%h", b_rd_a, c_INIT); end
        total++; if (b_rd_b !== 32'd0) begin bad++; $display("FAIL oor_r15_b got=%h want=%h", b_rd_b, 32'd0); end
    endtask

    task automatic test_masked_write();
        rd_addr_a = 4'd0; rd_addr_b = 4'd1;
        write(4'd5, 32'h1122_3344, 4'hF);
        step();
        write(4'd5, 32'hAABB_CCDD, 4'b0101);
        rd_addr_b = 4'd5;
        step();
        total++; if (a_rd_b !== 32'h11BB_33DD) begin bad++; $display("FAIL mask_bypass_a got=%h want=%h", a_rd_b, 32'h11BB_33DD); end
        total++; if (b_rd_b !== 32'h1122_3344) begin bad++; $display("FAIL mask_nobypass_b got=%h want=%h", b_rd_b, 32'h1122_3344); end
        wr_en = 1'b0; rd_addr_a = 4'd5;
        step();
        total++; if (a_rd_a !== 32'h11BB_33DD) begin bad++; $display("FAIL mask_read_a got=%h want=%h", a_rd_a, 32'h11BB_33DD); end
        total++; if (b_rd_a !== 32'h11BB_33DD) begin bad++; $display("FAIL mask_read_b got=%h want=%h", b_rd_a, 32'h11BB_33DD); end
        // Zero mask with wr_en is a no-op, including on the bypass path.
        write(4'd5, 32'h0000_0000, 4'h0);
        step();
        total++; if (a_rd_a !== 32'h11BB_33DD) begin bad++; $display("FAIL mask0_bypass_a got=%h want=%h", a_rd_a, 32'h11BB_33DD); end
        wr_en = 1'b0;
        step();
        total++; if (b_rd_a !== 32'h11BB_33DD) begin bad++; $display("FAIL mask0_hold_b got=%h want=%h", b_rd_a, 32'h11BB_33DD); end
    endtask

    task automatic test_bypass();
        write(4'd7, 32'd20, 4'hF);
        rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        step();
        write(4'd7, 32'd30, 4'hF);
        rd_addr_a = 4'd7; rd_addr_b = 4'd7;
        step();
        total++; if (a_rd_a !== 32'd30) begin bad++; $display("FAIL bypass_on_a got=%0d want=%0d", a_rd_a, 30); end
        total++; if (a_rd_b !== 32'd30) begin bad++; $display("FAIL bypass_on_b got=%0d want=%0d", a_rd_b, 30); end
        total++; if (b_rd_a !== 32'd20) begin bad++; $display("FAIL bypass_off_a got=%0d want=%0d", b_rd_a, 20); end
        total++; if (b_rd_b !== 32'd20) begin bad++; $display("FAIL bypass_off_b got=%0d want=%0d", b_rd_b, 20); end
        wr_en = 1'b0;
        step();
        total++; if (b_rd_a !== 32'd30) begin bad++; $display("FAIL bypass_off_next got=%0d want=%0d", b_rd_a, 30); end
        total++; if (a_rd_a !== 32'd30) begin bad++; $display("FAIL bypass_on_next got=%0d want=%0d", a_rd_a, 30); end
    endtask

    task automatic test_hold();
        write(4'd2, 32'd77, 4'hF);
        step();
        wr_en = 1'b0; wr_addr = 4'd2; wr_data = 32'd99; wr_mask = 4'hF;
        rd_addr_a = 4'd2; rd_addr_b = 4'd2;
        step();
        step();
        total++; if (a_rd_a !== 32'd77) begin bad++; $display("FAIL hold_a got=%0d want=%0d", a_rd_a, 77); end
        total++; if (b_rd_b !== 32'd77) begin bad++; $display("FAIL hold_b got=%0d want=%0d", b_rd_b, 77); end
    endtask

    task automatic test_out_of_range();
        write(4'd13, 32'h0000_1234, 4'hF);
        rd_addr_a = 4'd13; rd_addr_b = 4'd1;
        step();
        total++; if (b_rd_a !== 32'd0) begin bad++; $display("FAIL oor_same_cycle got=%h want=%h", b_rd_a, 32'd0); end
        wr_en = 1'b0;
        step();
        total++; if (b_rd_a !== 32'd0) begin bad++; $display("FAIL oor_read_b got=%h want=%h", b_rd_a, 32'd0); end
        total++; if (b_rd_b !== c_INIT) begin bad++; $display("FAIL oor_nowrap_r1 got=%h want=%h", b_rd_b, c_INIT); end
        total++; if (a_rd_a !== 32'h0000_1234) begin bad++; $display("FAIL inrange_r13_a got=%h want=%h", a_rd_a, 32'h0000_1234); end
        rd_addr_a = 4'd5; rd_addr_b = 4'd7;
        step();
        total++; if (b_rd_a !== 32'h11BB_33DD) begin bad++; $display("FAIL oor_r5_untouched got=%h want=%h", b_rd_a, 32'h11BB_33DD); end
        total++; if (b_rd_b !== 32'd30) begin bad++; $display("FAIL oor_r7_untouched got=%0d want=%0d", b_rd_b, 30); end
    endtask

    task automatic test_clear_priority();
        write(4'd4, 32'd55, 4'hF);
        clear = 1'b1; rd_addr_a = 4'd4; rd_addr_b = 4'd5;
        step();
        total++; if (a_rd_a !== 32'd0) begin bad++; $display("FAIL clr_rd_zero_a got=%h want=%h", a_rd_a, 32'd0); end
        total++; if (b_rd_a !== 32'd0) begin bad++; $display("FAIL clr_rd_zero_b got=%h want=%h", b_rd_a, 32'd0); end
        clear = 1'b0; wr_en = 1'b0;
        step();
        total++; if (a_rd_a !== c_INIT) begin bad++; $display("FAIL clr_prio_a got=%h want=%h", a_rd_a, c_INIT); end
        total++; if (b_rd_a !== c_INIT) begin bad++; $display("FAIL clr_prio_b got=%h want=%h", b_rd_a, c_INIT); end
        total++; if (a_rd_b !== c_INIT) begin bad++; $display("FAIL clr_r5_init got=%h want=%h", a_rd_b, c_INIT); end
    endtask

    task automatic test_r0();
        reg_word_t exp_now_a, exp_now_b, exp_after;
`ifdef REGFILE_R0_ZERO_EN
        exp_now_a = 32'd0; exp_now_b = 32'd0; exp_after = 32'd0;
`else
        exp_now_a = 32'hFFFF_FFFF; exp_now_b = c_INIT; exp_after = 32'hFFFF_FFFF;
`endif
        write(4'd0, 32'hFFFF_FFFF, 4'hF);
        rd_addr_a = 4'd0; rd_addr_b = 4'd0;
        step();
        total++; if (a_rd_a !== exp_now_a) begin bad++; $display("FAIL r0_bypass_a got=%h want=%h", a_rd_a, exp_now_a); end
        total++; if (b_rd_a !== exp_now_b) begin bad++; $display("FAIL r0_nobypass_b got=%h want=%h", b_rd_a, exp_now_b); end
        wr_en = 1'b0;
        step();
        total++; if (a_rd_b !== exp_after) begin bad++; $display("FAIL r0_after_a got=%h want=%h", a_rd_b, exp_after); end
        total++; if (b_rd_b !== exp_after) begin bad++; $display("FAIL r0_after_b got=%h want=%h", b_rd_b, exp_after); end
    endtask

    task automatic test_back_to_back();
        // Consecutive writes to different registers, each read back the next cycle.
        write(4'd8, 32'hCAFE_0008, 4'hF);
        step();
        write(4'd9, 32'hCAFE_0009, 4'b1100);
        rd_addr_a = 4'd8; rd_addr_b = 4'd9;
        step();
        wr_en = 1'b0;
        step();
        total++; if (a_rd_a !== 32'hCAFE_0008) begin bad++; $display("FAIL b2b_r8 got=%h want=%h", a_rd_a, 32'hCAFE_0008); end
        total++; if (b_rd_b !== 32'hCAFE_BEEF) begin bad++; $display("FAIL b2b_r9_merge got=%h want=%h", b_rd_b, 32'hCAFE_BEEF); end
    endtask

    initial begin
        clear = 1'b0; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_mask = '0;
        rd_addr_a = '0; rd_addr_b = '0;
        test_reset();
        test_masked_write();
        test_bypass();
        test_hold();
        test_out_of_range();
        test_clear_priority();
        test_back_to_back();
        test_r0();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_register_file

`default_nettype wire
